// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage. A registered in_ready breaks the
// ready path, and bubbles present all-zero control/data downstream.
module pipe_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               clr_cnt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e             state_q, state_d;
  entry_t             main_q, main_d, skid_q, skid_d, in_ent;
  logic               in_ready_q;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               in_fire, out_fire;

  assign in_ent    = '{ctrl: in_ctrl, data: in_data};
  assign out_valid = (state_q == FULL) || (state_q == SKID);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = FULL;
          main_d  = in_ent;
        end
        FULL: unique case ({in_fire, out_fire})
          2'b11: main_d = in_ent;
          2'b10: begin
            skid_d  = in_ent;
            state_d = SKID;
          end
          2'b01: begin
            main_d  = '0;
            state_d = EMPTY;
          end
          default: ;
        endcase
        // Inputs are ignored here: in_ready is already low.
        SKID: if (out_fire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_cnt)
      stall_d = '0;
    else if (out_valid && !out_ready && !(&stall_q))
      stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != SKID);
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    unique case (state_q)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_ctrl  = out_valid ? main_q.ctrl : '0;
  assign out_data  = out_valid ? main_q.data : '0;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random traffic against
// a queue-based model of a two-deep FIFO stage.
module tb_pipe_skid_stage;
  localparam int DW = 32, CW = 8, SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0, rst = 1'b0, flush = 1'b0, clr_cnt = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .STALL_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: the stage is a FIFO of capacity 2 whose ready reflects the
  // occupancy after the last edge (and is low until the first edge after reset).
  logic [CW+DW-1:0] q[$];
  int  cnt_m = 0;
  bit  started = 0;
  bit  e_vld, e_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    e_vld = (q.size() > 0);
    e_rdy = started && (q.size() < 2);
    ec = '0;
    ed = '0;
    if (e_vld) begin
      ec = q[0][CW+DW-1:DW];
      ed = q[0][DW-1:0];
    end
    chk("out_valid", 64'(out_valid), 64'(e_vld));
    chk("in_ready",  64'(in_ready),  64'(e_rdy));
    chk("out_ctrl",  64'(out_ctrl),  64'(ec));
    chk("out_data",  64'(out_data),  64'(ed));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
  endtask

  task automatic cyc(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input bit r, input bit fl = 0, input bit cl = 0);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = fl; clr_cnt = cl;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (cl) cnt_m = 0;
    else if (e_vld && !r && cnt_m < SMAX) cnt_m++;
    if (fl) q.delete();
    else begin
      if (e_vld && r) void'(q.pop_front());
      if (v && e_rdy) q.push_back({c, d});
    end
    started = 1;
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_vld"},  64'(out_valid), 64'(0));
    chk({tag, "_rdy"},  64'(in_ready),  64'(0));
    chk({tag, "_ctrl"}, 64'(out_ctrl),  64'(0));
    chk({tag, "_data"}, 64'(out_data),  64'(0));
    chk({tag, "_occ"},  64'(occupancy), 64'(0));
    chk({tag, "_cnt"},  64'(stall_cnt), 64'(0));
  endtask

  initial begin
    #2;
    rst_chk("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Streaming: 1..8 back to back with out_ready high.
    for (int i = 1; i <= 8; i++) cyc(1, CW'(i), DW'(i), 1);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);

    // Skid: A held, B goes to skid, C refused until ready returns.
    cyc(1, 8'h0A, 32'hAAAA, 0);
    cyc(1, 8'h0B, 32'hBBBB, 0);
    chk("skid_occ", 64'(occupancy), 64'(2));
    chk("skid_rdy", 64'(in_ready), 64'(0));
    cyc(1, 8'h0C, 32'hCCCC, 0);
    cyc(1, 8'h0C, 32'hCCCC, 1);
    cyc(1, 8'h0C, 32'hCCCC, 1);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);

    // Flush in SKID with an offered input.
    cyc(1, 8'h11, 32'h1111, 0);
    cyc(1, 8'h22, 32'h2222, 0);
    cyc(1, 8'hFF, 32'hDEAD, 0, 1);
    chk("flush_vld",  64'(out_valid), 64'(0));
    chk("flush_ctrl", 64'(out_ctrl),  64'(0));
    chk("flush_occ",  64'(occupancy), 64'(0));
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 1);

    // Saturation then clear while still stalled.
    cyc(1, 8'h33, 32'h3333, 0);
    for (int i = 0; i < 20; i++) cyc(0, '0, '0, 0);
    chk("sat_cnt", 64'(stall_cnt), 64'(SMAX));
    cyc(0, '0, '0, 0, 0, 1);
    chk("clr_cnt", 64'(stall_cnt), 64'(0));

    // Async reset pulse mid-cycle while in SKID.
    cyc(1, 8'h44, 32'h4444, 0);
    chk("pre_rst_occ", 64'(occupancy), 64'(2));
    #1 rst = 1'b0;
    #1 rst_chk("async_rst");
    q.delete(); cnt_m = 0; started = 0;
    #1 rst = 1'b1;
    cyc(0, '0, '0, 1);
    cyc(1, 8'h5A, 32'h1234, 1);
    chk("rst_entry", 64'(out_data), 64'(32'h1234));
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);

    // Random traffic against the FIFO model.
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
Parameters:
REQ-001 DATA_W, default 32: width of the datapath payload (operands, immediates, PCs).
REQ-002 CTRL_W, default 8: width of the control payload (RegWrite, MemWrite, ResultSrc and similar bits).
REQ-003 STALL_W, default 16: width of the stall performance counter.
Ports (name, direction, width, meaning):
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 clr_cnt  in  1  synchronous clear of stall_cnt.
REQ-008 in_valid  in  1  upstream entry valid.
REQ-009 in_ready  out  1  stage can accept an entry; a registered output.
REQ-010 in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 in_data  in  DATA_W  upstream data payload.
REQ-012 out_valid  out  1  downstream entry valid.
REQ-013 out_ready  in  1  downstream accepts the entry.
REQ-014 out_ctrl  out  CTRL_W  control payload of the head entry.
REQ-015 out_data  out  DATA_W  data payload of the head entry.
REQ-016 occupancy  out  2  number of held entries (0, 1 or 2).
REQ-017 stall_cnt  out  STALL_W  saturating count of back-pressure cycles.

Function
REQ-018 The block SHALL hold at most two entries: a main register (the head) and a skid register.
REQ-019 The state machine SHALL have three states: EMPTY (occupancy 0), FULL (occupancy 1), SKID (occupancy 2).
REQ-020 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-021 Output decode:
- out_valid SHALL be 1 in FULL and SKID.
- in_ready SHALL be 1 in EMPTY and FULL, and 0 in SKID.
REQ-022 Transitions from EMPTY: in_fire loads main and moves to FULL; otherwise stay in EMPTY.
REQ-023 Transitions from FULL:
- in_fire & out_fire: load main with the new entry, stay in FULL.
- in_fire only: load skid, move to SKID.
- out_fire only: move to EMPTY.
- neither: hold.
REQ-024 Transitions from SKID: out_fire copies skid into main and moves to FULL; inputs are ignored while in SKID.
REQ-025 Latency from in_fire to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 entry per cycle when out_ready is held at 1.
REQ-026 Entries SHALL leave in arrival order; no entry SHALL be duplicated or lost unless flushed.
REQ-027 Control bubble rule: out_ctrl SHALL be all-zero whenever out_valid = 0, so an empty stage never presents a write-enable.
REQ-028 out_data SHALL be all-zero whenever out_valid = 0.
REQ-029 flush = 1 on a clock edge SHALL:
- move the state to EMPTY;
- zero the main and skid registers;
- discard any in_fire in that cycle.
flush SHALL take priority over all transitions.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with out_valid & !out_ready, and SHALL saturate at 2^STALL_W-1 without wrapping.
REQ-031 clr_cnt SHALL zero stall_cnt. When clr_cnt and the increment condition occur in the same cycle, the result SHALL be 0.
REQ-032 flush SHALL NOT affect stall_cnt.
REQ-033 The block SHALL contain no combinational path from in_valid to in_ready or from out_ready to in_ready.

Reset
REQ-034 While rst = 0, the block SHALL immediately and asynchronously force:
- state = EMPTY, occupancy = 0, in_ready = 0;
- out_valid = 0, out_ctrl = 0, out_data = 0;
- the skid register = 0, stall_cnt = 0.
REQ-035 On the first edge after rst deasserts, in_ready SHALL be 1. Asserting rst in SKID with a transfer in flight SHALL drop both entries and produce no out_fire afterwards.

Verification
REQ-036 Streaming: out_ready = 1, in_valid = 1 for 8 cycles with in_data = 1..8 -> out_data = 1..8 on consecutive cycles starting 1 cycle later; occupancy stays 1.
REQ-037 Skid: fill with A, drop out_ready, present B -> state SKID, in_ready = 0, stall_cnt counts. Raise out_ready -> A then B emitted, C accepted only after in_ready returns to 1.
REQ-038 Flush in SKID with in_valid = 1 and in_ctrl = 8'hFF -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0; the flushed input never appears at the output.
REQ-039 Saturation: STALL_W = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cnt = 15. Then clr_cnt with the stall still active -> stall_cnt = 0.
REQ-040 Async reset mid-stream: pulse rst low between clock edges while in SKID -> outputs zero immediately; after release, a single entry 0x1234 emerges unaltered.
REQ-041 Random valid/ready over 10k cycles with a scoreboard -> in-order delivery with no loss or duplication, and out_ctrl = 0 on every cycle where out_valid = 0.
